// File: rtl/unique_0.sv
// -----------------------------------------------------------------------------
// unique_0 : instruction-check stage between fetch and the control unit.
//
// Each accepted word is classified:
//   - control instruction (opcode 6'b111111): drives the communication sideband
//     (signal_out / communication_enable_out) and the PC-select line.
//   - ordinary instruction: forwarded on ins_out with the CU enabled.
// All outputs are registered (1-cycle latency).
//
// Ports:
//   clock                    in   system clock, rising edge
//   reset                    in   asynchronous, active-high reset
//   ins_in[31:0]             in   fetched instruction word
//   wait_for_next_in         in   1 = current word invalid, hold state
//   signal_out[18:0]         out  ins_in[25:7] of last accepted control word
//   ins_out[31:0]            out  last accepted ordinary instruction
//   pc_choice_out            out  1 = sequential fetch, 0 = start-redirect
//   cu_enable_out            out  control-unit enable
//   communication_enable_out out  sideband communication valid
//
// Build option:
//   UNIQUE_0_STOP_PULSE_EN  defined   : STOP raises communication_enable_out
//                                       for exactly one cycle.
//                           undefined : STOP holds communication_enable_out
//                                       high, like END.
// -----------------------------------------------------------------------------
module unique_0 #(
    parameter int unsigned BUS_WIDTH = 32
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [BUS_WIDTH-1:0] ins_in,
    input  logic                 wait_for_next_in,
    output logic [18:0]          signal_out,
    output logic [BUS_WIDTH-1:0] ins_out,
    output logic                 pc_choice_out,
    output logic                 cu_enable_out,
    output logic                 communication_enable_out
);

    localparam logic [5:0] CTRL_OPCODE = 6'b111111;

    typedef enum logic [1:0] {
        SUB_END   = 2'b00,
        SUB_RSVD  = 2'b01,
        SUB_START = 2'b10,
        SUB_STOP  = 2'b11
    } subcode_e;

    logic [18:0]          signal_q, signal_d;
    logic [BUS_WIDTH-1:0] ins_q, ins_d;
    logic                 pc_choice_q, pc_choice_d;
    logic                 cu_enable_q, cu_enable_d;
    logic                 comm_enable_q, comm_enable_d;
`ifdef UNIQUE_0_STOP_PULSE_EN
    logic                 stop_pulse_q, stop_pulse_d;
`endif

    logic     is_ctrl;
    subcode_e subcode;

    always_comb begin
        is_ctrl = (ins_in[31:26] == CTRL_OPCODE);
        subcode = subcode_e'(ins_in[25:24]);
    end

    always_comb begin
        signal_d      = signal_q;
        ins_d         = ins_q;
        pc_choice_d   = pc_choice_q;
        cu_enable_d   = cu_enable_q;
        comm_enable_d = comm_enable_q;
`ifdef UNIQUE_0_STOP_PULSE_EN
        // The STOP pulse ends on the next edge regardless of wait; an accepted
        // START/END/STOP below re-raises the output on that same edge.
        stop_pulse_d = 1'b0;
        if (stop_pulse_q) begin
            comm_enable_d = 1'b0;
        end
`endif
        if (!wait_for_next_in) begin
            if (is_ctrl) begin
                unique case (subcode)
                    SUB_START: begin
                        signal_d      = ins_in[25:7];
                        pc_choice_d   = 1'b0;
                        comm_enable_d = 1'b1;
                    end
                    SUB_STOP: begin
                        signal_d      = ins_in[25:7];
                        cu_enable_d   = 1'b0;
                        comm_enable_d = 1'b1;
`ifdef UNIQUE_0_STOP_PULSE_EN
                        stop_pulse_d  = 1'b1;
`endif
                    end
                    SUB_END: begin
                        signal_d      = ins_in[25:7];
                        comm_enable_d = 1'b1;
                    end
                    SUB_RSVD: begin
                        // reserved: no change
                    end
                    default: begin
                    end
                endcase
            end else begin
                ins_d         = ins_in;
                cu_enable_d   = 1'b1;
                comm_enable_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            signal_q      <= '0;
            ins_q         <= '0;
            pc_choice_q   <= 1'b1;
            cu_enable_q   <= 1'b0;
            comm_enable_q <= 1'b0;
`ifdef UNIQUE_0_STOP_PULSE_EN
            stop_pulse_q  <= 1'b0;
`endif
        end else begin
            signal_q      <= signal_d;
            ins_q         <= ins_d;
            pc_choice_q   <= pc_choice_d;
            cu_enable_q   <= cu_enable_d;
            comm_enable_q <= comm_enable_d;
`ifdef UNIQUE_0_STOP_PULSE_EN
            stop_pulse_q  <= stop_pulse_d;
`endif
        end
    end

    always_comb begin
        signal_out               = signal_q;
        ins_out                  = ins_q;
        pc_choice_out            = pc_choice_q;
        cu_enable_out            = cu_enable_q;
        communication_enable_out = comm_enable_q;
    end

endmodule

// File: tb/tb_unique_0.sv
// -----------------------------------------------------------------------------
// Testbench for unique_0: a reference model computes expected outputs as each
// word is driven; they are queued and compared one cycle later.
// -----------------------------------------------------------------------------
module tb_unique_0;

    logic        clock;
    logic        reset;
    logic [31:0] ins_in;
    logic        wait_for_next_in;
    logic [18:0] signal_out;
    logic [31:0] ins_out;
    logic        pc_choice_out;
    logic        cu_enable_out;
    logic        communication_enable_out;

    unique_0 #(.BUS_WIDTH(32)) dut (
        .clock                    (clock),
        .reset                    (reset),
        .ins_in                   (ins_in),
        .wait_for_next_in         (wait_for_next_in),
        .signal_out               (signal_out),
        .ins_out                  (ins_out),
        .pc_choice_out            (pc_choice_out),
        .cu_enable_out            (cu_enable_out),
        .communication_enable_out (communication_enable_out)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct packed {
        logic [18:0] sig;
        logic [31:0] ins;
        logic        pc;
        logic        cu;
        logic        comm;
    } exp_t;

    exp_t exp_q[$];

    int checks   = 0;
    int failures = 0;

    // reference model state
    logic [18:0] m_sig;
    logic [31:0] m_ins;
    logic        m_pc;
    logic        m_cu;
    logic        m_comm;
    logic        m_pulse;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_sig   = '0;
        m_ins   = '0;
        m_pc    = 1'b1;
        m_cu    = 1'b0;
        m_comm  = 1'b0;
        m_pulse = 1'b0;
    endtask

    task automatic model_step(input logic [31:0] ins, input logic wt);
        logic pulse_next;
        pulse_next = 1'b0;
`ifdef UNIQUE_0_STOP_PULSE_EN
        if (m_pulse) m_comm = 1'b0;
`endif
        if (!wt) begin
            if (ins[31:26] == 6'b111111) begin
                if (ins[25:24] == 2'b10) begin
                    m_sig = ins[25:7]; m_pc = 1'b0; m_comm = 1'b1;
                end else if (ins[25:24] == 2'b11) begin
                    m_sig = ins[25:7]; m_cu = 1'b0; m_comm = 1'b1;
`ifdef UNIQUE_0_STOP_PULSE_EN
                    pulse_next = 1'b1;
`endif
                end else if (ins[25:24] == 2'b00) begin
                    m_sig = ins[25:7]; m_comm = 1'b1;
                end
            end else begin
                m_ins = ins; m_cu = 1'b1; m_comm = 1'b0;
            end
        end
        m_pulse = pulse_next;
    endtask

    task automatic compare_outputs(input string tag);
        exp_t e;
        if (exp_q.size() == 0) begin
            check({tag, ".queue_empty"}, 32'd1, 32'd0);
            return;
        end
        e = exp_q.pop_front();
        check({tag, ".sig"},  {13'd0, signal_out},             {13'd0, e.sig});
        check({tag, ".ins"},  ins_out,                         e.ins);
        check({tag, ".pc"},   {31'd0, pc_choice_out},          {31'd0, e.pc});
        check({tag, ".cu"},   {31'd0, cu_enable_out},          {31'd0, e.cu});
        check({tag, ".comm"}, {31'd0, communication_enable_out}, {31'd0, e.comm});
    endtask

    // drive one word at the negedge, push expectation, compare after the edge
    task automatic step(input string tag, input logic [31:0] ins, input logic wt);
        @(negedge clock);
        ins_in           = ins;
        wait_for_next_in = wt;
        model_step(ins, wt);
        exp_q.push_back('{sig: m_sig, ins: m_ins, pc: m_pc, cu: m_cu, comm: m_comm});
        @(posedge clock);
        #1;
        compare_outputs(tag);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, ".sig"},  {13'd0, signal_out},               32'd0);
        check({tag, ".ins"},  ins_out,                           32'd0);
        check({tag, ".pc"},   {31'd0, pc_choice_out},            32'd1);
        check({tag, ".cu"},   {31'd0, cu_enable_out},            32'd0);
        check({tag, ".comm"}, {31'd0, communication_enable_out}, 32'd0);
    endtask

    logic [31:0] rnd;
    logic [31:0] pool [6];

    initial begin
        pool[0] = 32'hFE000000;  // START
        pool[1] = 32'hFF000080;  // STOP
        pool[2] = 32'hFC000080;  // END
        pool[3] = 32'hFD000000;  // reserved
        pool[4] = 32'h12345678;  // ordinary
        pool[5] = 32'hA5A5F00F;  // ordinary

        ins_in           = '0;
        wait_for_next_in = 1'b1;
        reset            = 1'b1;
        model_reset();
        repeat (2) @(posedge clock);
        #2;
        reset = 1'b0;
        #1;
        check_reset_values("reset");

        step("ordinary",       32'h12345678, 1'b0);
        step("start",          32'hFE000000, 1'b0);
        check("start.sig_lit", {13'd0, signal_out}, 32'h00040000);
        step("ord_after_start", 32'h12345678, 1'b0);
        step("stop",           32'hFF000080, 1'b0);
        check("stop.sig_lit",  {13'd0, signal_out}, 32'h00060001);
        step("stop_wait1",     32'hFF000080, 1'b1);
        step("stop_wait2",     32'hFF000080, 1'b1);
        step("stop_stop_a",    32'hFF000080, 1'b0);
        step("stop_stop_b",    32'hFF000080, 1'b0);
        step("stop_then_end",  32'hFC000080, 1'b0);
        check("end.sig_lit",   {13'd0, signal_out}, 32'h00000001);
        step("end_hold",       32'hFD000000, 1'b0);
        step("reserved2",      32'hFD123456, 1'b0);
        step("ord2",           32'hA5A5F00F, 1'b0);
        step("ord3",           32'h00000000, 1'b0);
        step("stop_then_start_a", 32'hFF000080, 1'b0);
        step("stop_then_start_b", 32'hFE000180, 1'b0);

        for (int unsigned i = 0; i < 60; i++) begin
            rnd = $urandom;
            if (rnd[3:0] < 4'd9) rnd = pool[rnd[7:4] % 6] ^ {8'h00, rnd[31:8]} & 32'h03FFFF80;
            step("rand", rnd, ($urandom_range(0, 3) == 0));
        end

        // wait hold with a START word present, then async reset mid-hold
        for (int unsigned i = 0; i < 4; i++) begin
            step("hold", 32'hFE000000, 1'b1);
        end
        @(negedge clock);
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        check_reset_values("async_reset");
        @(posedge clock);
        #2;
        reset = 1'b0;
        #1;
        check_reset_values("after_reset");
        step("post_reset_ord", 32'h0BADF00D, 1'b0);

        check("queue_drained", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule

// File: doc/unique_0.md
# unique_0

Instruction-check stage between the instruction fetch unit and the control unit. Each cycle it inspects the fetched 32-bit word: control instructions (opcode 6'b111111) drive the communication sideband and PC-select line, and ordinary instructions pass through to the control unit with the CU enabled. All outputs are registered.

## Interface
- BUS_WIDTH, 32, instruction width; fixed at 32 (the field positions below assume 32).
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- ins_in  in  32  fetched instruction word.
- wait_for_next_in  in  1  high = the current word is not valid; hold all state.
- signal_out  out  19  control payload, ins_in[25:7] of the last accepted control instruction.
- ins_out  out  32  last accepted ordinary instruction.
- pc_choice_out  out  1  PC source select; 1 = sequential fetch, 0 = start-redirect.
- cu_enable_out  out  1  control-unit enable.
- communication_enable_out  out  1  sideband communication valid.

## Operation
- Reset values: signal_out=0, ins_out=0, pc_choice_out=1, cu_enable_out=0, communication_enable_out=0, internal stop-pulse flag=0.
- A word is accepted on a rising edge when wait_for_next_in=0. If wait_for_next_in=1, nothing updates except the stop-pulse clear described below.
- Control instruction: ins_in[31:26]==6'b111111. Decode the subcode ins_in[25:24]:
  - 2'b10 START: signal_out<=ins_in[25:7]; pc_choice_out<=0; communication_enable_out<=1 (held).
  - 2'b11 STOP: signal_out<=ins_in[25:7]; cu_enable_out<=0; communication_enable_out<=1 for exactly one cycle (see Configuration).
  - 2'b00 END: signal_out<=ins_in[25:7]; communication_enable_out<=1 (held).
  - 2'b01: reserved. No output changes.
- Ordinary instruction (any other opcode): ins_out<=ins_in; cu_enable_out<=1; communication_enable_out<=0.
- A control instruction never updates ins_out. An ordinary instruction never updates signal_out.
- pc_choice_out is sticky. Once it is 0, only reset returns it to 1.
- cu_enable_out stays at its last value across control instructions other than STOP.

## Timing
- Latency: 1 cycle. Outputs reflect the word accepted at edge N immediately after edge N.
- STOP pulse: communication_enable_out is high for the single cycle after the STOP edge. It clears on the next edge unconditionally, even if wait_for_next_in=1.
  - If that next edge accepts START or END, the output stays 1 (held).
  - If that next edge accepts a second STOP, the output stays 1 and a new one-cycle pulse begins.
- Back-to-back ordinary instructions: one per cycle, no bubbles.
- Reset asserted mid-operation: all outputs take their reset values immediately, independent of the clock. Operation resumes on the first rising edge after reset deasserts.

## Configuration
- UNIQUE_0_STOP_PULSE_EN, defined: STOP produces the one-cycle communication pulse described above, using the internal stop-pulse flag.
- UNIQUE_0_STOP_PULSE_EN, undefined: there is no stop-pulse flag. STOP sets communication_enable_out to 1 and holds it, exactly like END. All other behaviour is identical.

## Test plan
- Reset check: assert reset, then release. Required: pc_choice_out=1, cu_enable_out=0, communication_enable_out=0, signal_out=0, ins_out=0.
- Ordinary instruction: ins_in=32'h12345678 with wait=0. Required after one edge: ins_out=32'h12345678, cu_enable_out=1, communication_enable_out=0.
- START: ins_in=32'hFE000000. Required: signal_out=19'h40000, pc_choice_out=0, communication_enable_out=1. Then send 32'h12345678. Required: communication_enable_out=0, pc_choice_out still 0.
- STOP with macro defined: ins_in=32'hFF000080, with wait=1 afterwards. Required: signal_out=19'h60001, cu_enable_out=0, communication_enable_out=1 for exactly one cycle, then 0.
- END, then reserved: END 32'hFC000080 gives signal_out=19'h00001 and communication_enable_out held at 1. Reserved 32'hFD000000 then leaves all outputs unchanged.
- Wait hold: wait_for_next_in=1 with ins_in=32'hFE000000. Required: no output changes for multiple cycles; asynchronous reset asserted mid-hold clears all outputs immediately.
